// File: rtl/vga_pkg.sv
// Shared types and constants for the vblank arbiter and its benches.
package vga_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StGrant,
    StDrain
  } arb_state_e;

  localparam int unsigned NReqDefault       = 4;
  localparam int unsigned TimeoutCycDefault = 4096;

  // 1280x1024 @ 60 Hz raster: vertical blanking length in lines and pixel clocks.
  localparam int unsigned HActive     = 1280;
  localparam int unsigned HTotal      = 1688;
  localparam int unsigned VActive     = 1024;
  localparam int unsigned VTotal      = 1066;
  localparam int unsigned VBlankLines = VTotal - VActive;
  localparam int unsigned VBlankCyc   = VBlankLines * HTotal;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index after last_id_i, wrapping at N_REQ.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [2:0]       last_id_i,
  output logic             valid_o,
  output logic [2:0]       id_o
);

  logic [7:0]  elig8;
  logic [2:0]  idx;
  int unsigned idx_int;

  assign elig8 = 8'(eligible_i);

  // Scan N_REQ positions starting one past the last served index; keep the first hit.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx_int = 0;
    idx     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx_int = (32'(last_id_i) + k) % N_REQ;
      idx     = 3'(idx_int);
      if (!valid_o && elig8[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/vblank_arbiter.sv
// Grants frame-resource access to one requester at a time during vertical blanking.
// Each requester is served at most once per window. Optional per-grant watchdog is
// enabled by defining VBLANK_ARB_TIMEOUT_EN.
module vblank_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned N_REQ       = NReqDefault,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             vblnk,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_id,
  output logic             frame_start,
  output logic             abort
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  arb_state_e       state_q, state_d;
  logic             vblnk_q;
  logic             armed_q, armed_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       gnt_id_q, gnt_id_d;
  logic             frame_start_q;
  logic             abort_q, abort_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic [2:0]       last_id_q, last_id_d;

  logic             win_open;
  logic             win_close;
  logic             done_hit;
  logic             timeout;
  logic             sel_valid;
  logic [2:0]       sel_id;

  // armed_q blocks a false rising edge when reset releases in the middle of vblank.
  assign win_open  = vblnk & ~vblnk_q & armed_q;
  assign win_close = ~vblnk & vblnk_q;
  assign armed_d   = armed_q | ~vblnk;
  // gnt_q is one-hot, so this is done[gnt_id] without an index.
  assign done_hit  = |(done & gnt_q);

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr_arbiter (
    .eligible_i(req & ~served_q),
    .last_id_i (last_id_q),
    .valid_o   (sel_valid),
    .id_o      (sel_id)
  );

`ifdef VBLANK_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC);

  logic [WdW-1:0] wdog_q, wdog_d;

  assign timeout = (state_q == StGrant) && (wdog_q == WdW'(TIMEOUT_CYC - 1));
  // Count cycles spent in GRANT; restarts at zero on every new grant.
  assign wdog_d  = (state_q == StGrant) ? wdog_q + 1'b1 : '0;

  // Watchdog counter register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    served_d  = served_q;
    last_id_d = last_id_q;
    abort_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        if (win_open) begin
          served_d = '0;
          state_d  = StArb;
        end
      end
      StArb: begin
        if (win_close) begin
          state_d = StIdle;
        end else if (sel_valid) begin
          gnt_d    = N_REQ'(1) << sel_id;
          gnt_id_d = sel_id;
          state_d  = StGrant;
        end
      end
      StGrant: begin
        if (done_hit) begin
          // Done wins over a coincident close: no abort, and the window is over.
          gnt_d     = '0;
          gnt_id_d  = '0;
          served_d  = served_q | gnt_q;
          last_id_d = gnt_id_q;
          state_d   = win_close ? StIdle : StArb;
        end else if (win_close) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          served_d = served_q | gnt_q;
          abort_d  = 1'b1;
          state_d  = StDrain;
        end else if (timeout) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          served_d = served_q | gnt_q;
          abort_d  = 1'b1;
          state_d  = StArb;
        end
      end
      StDrain: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        state_d  = StIdle;
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        state_d  = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      vblnk_q       <= 1'b0;
      armed_q       <= 1'b0;
      gnt_q         <= '0;
      gnt_id_q      <= '0;
      frame_start_q <= 1'b0;
      abort_q       <= 1'b0;
      served_q      <= '0;
      last_id_q     <= 3'(N_REQ - 1);
    end else begin
      state_q       <= state_d;
      vblnk_q       <= vblnk;
      armed_q       <= armed_d;
      gnt_q         <= gnt_d;
      gnt_id_q      <= gnt_id_d;
      frame_start_q <= win_open;
      abort_q       <= abort_d;
      served_q      <= served_d;
      last_id_q     <= last_id_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign frame_start = frame_start_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_vblank_arbiter.sv
// Directed bench for vblank_arbiter (4 requesters, watchdog limit 16 when enabled).
module tb_vblank_arbiter;

  localparam int unsigned NReq = 4;

  logic            pclk;
  logic            rst_n;
  logic            vblnk;
  logic [NReq-1:0] req;
  logic [NReq-1:0] done;
  logic [NReq-1:0] gnt;
  logic [2:0]      gnt_id;
  logic            frame_start;
  logic            abort;

  int n_chk;
  int n_bad;

  vblank_arbiter #(
    .N_REQ      (NReq),
    .TIMEOUT_CYC(16)
  ) u_dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vblnk      (vblnk),
    .req        (req),
    .done       (done),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .frame_start(frame_start),
    .abort      (abort)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Wait (bounded) for any grant; n is the number of edges it took.
  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == '0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Expect a grant to exp_id after exp_wait edges, hold it, then end it with done.
  task automatic serve_one(input string tag, input int exp_id, input int exp_wait, input int hold);
    int n;
    logic [NReq-1:0] oh;
    oh = NReq'(1) << exp_id;
    wait_gnt(n);
    check_eq({tag, "_lat"}, n, exp_wait);
    check_eq({tag, "_id"}, gnt_id, exp_id);
    check_eq({tag, "_gnt"}, gnt, oh);
    repeat (hold - 1) tick();
    check_eq({tag, "_hold"}, gnt, oh);
    done = oh;
    tick();
    done = '0;
    check_eq({tag, "_drop"}, gnt, 0);
    check_eq({tag, "_noabort"}, abort, 0);
  endtask

  initial begin
    int n;
    int extra;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    vblnk = 1'b0;
    req   = '0;
    done  = '0;

    // Reset values
    tick();
    tick();
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_gnt_id", gnt_id, 0);
    check_eq("rst_fs", frame_start, 0);
    check_eq("rst_abort", abort, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Window 1: all requesting, served in order 0..3
    req   = 4'b1111;
    vblnk = 1'b1;
    tick();
    check_eq("w1_fs", frame_start, 1);
    tick();
    check_eq("w1_fs_pulse", frame_start, 0);
    check_eq("w1_g0_id", gnt_id, 0);
    repeat (8) tick();
    done = 4'b0001;
    tick();
    done = '0;
    check_eq("w1_g0_drop", gnt, 0);
    serve_one("w1_g1", 1, 1, 10);
    serve_one("w1_g2", 2, 1, 10);
    serve_one("w1_g3", 3, 1, 10);
    repeat (3) tick();
    check_eq("w1_no_regrant", gnt, 0);
    vblnk = 1'b0;
    tick();
    tick();
    check_eq("w1_closed", gnt, 0);

    // Window 2: restarts at 0; then close while gnt[1] held
    vblnk = 1'b1;
    tick();
    check_eq("w2_fs", frame_start, 1);
    serve_one("w2_g0", 0, 1, 10);
    wait_gnt(n);
    check_eq("w2_g1_lat", n, 1);
    check_eq("w2_g1_gnt", gnt, 4'b0010);
    vblnk = 1'b0;
    tick();
    check_eq("close_gnt", gnt, 0);
    check_eq("close_abort", abort, 1);
    tick();
    check_eq("close_abort_1cyc", abort, 0);
    check_eq("close_drain_gnt", gnt, 0);
    repeat (3) tick();
    check_eq("close_idle_gnt", gnt, 0);

    // Three windows with only req[2]: one grant each
    req = 4'b0100;
    for (int w = 0; w < 3; w++) begin
      vblnk = 1'b1;
      tick();
      check_eq("r2_fs", frame_start, 1);
      serve_one("r2", 2, 1, 3);
      extra = 0;
      repeat (10) begin
        tick();
        if (gnt != '0) extra++;
      end
      check_eq("r2_once", extra, 0);
      vblnk = 1'b0;
      tick();
      tick();
    end

    // done[3] coincident with window close: no abort; req drop does not revoke
    req   = 4'b1000;
    vblnk = 1'b1;
    tick();
    wait_gnt(n);
    check_eq("c_id", gnt_id, 3);
    req = '0;
    repeat (3) tick();
    check_eq("c_req_drop_hold", gnt, 4'b1000);
    done  = 4'b1000;
    vblnk = 1'b0;
    tick();
    done = '0;
    check_eq("c_gnt", gnt, 0);
    check_eq("c_abort", abort, 0);
    tick();
    check_eq("c_abort2", abort, 0);
    tick();

    // Async reset during GRANT, release mid-vblank
    req   = 4'b0011;
    vblnk = 1'b1;
    tick();
    wait_gnt(n);
    check_eq("d_pre_gnt", gnt, 4'b0001);
    rst_n = 1'b0;
    #1;
    check_eq("d_rst_gnt", gnt, 0);
    check_eq("d_rst_id", gnt_id, 0);
    check_eq("d_rst_abort", abort, 0);
    check_eq("d_rst_fs", frame_start, 0);
    tick();
    tick();
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      tick();
      if (gnt != '0 || frame_start) extra++;
    end
    check_eq("d_no_window", extra, 0);
    vblnk = 1'b0;
    tick();
    tick();
    vblnk = 1'b1;
    tick();
    check_eq("d_fs", frame_start, 1);
    wait_gnt(n);
    check_eq("d_lat", n, 1);
    check_eq("d_id", gnt_id, 0);

`ifdef VBLANK_ARB_TIMEOUT_EN
    // Watchdog: no done, grant drops after 16 cycles, next requester follows
    n = 0;
    while (gnt != '0 && n < 40) begin
      tick();
      n++;
    end
    check_eq("t_len", n, 16);
    check_eq("t_abort", abort, 1);
    tick();
    check_eq("t_abort_1cyc", abort, 0);
    check_eq("t_next", gnt, 4'b0010);
`else
    // No watchdog: grant held indefinitely inside the window
    extra = 0;
    repeat (40) begin
      tick();
      if (abort) extra++;
    end
    check_eq("t_hold", gnt, 4'b0001);
    check_eq("t_no_abort", extra, 0);
    done = 4'b0001;
    tick();
    done = '0;
    tick();
    check_eq("t_next", gnt, 4'b0010);
`endif

    vblnk = 1'b0;
    repeat (3) tick();
    check_eq("end_gnt", gnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vblank_arbiter.md
VBLANK_ARBITER -- requirements
Module: vblank_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter: TIMEOUT_CYC, default 4096, watchdog limit in pclk cycles per grant.
REQ-003 pclk  input  1  pixel clock; the only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 vblnk  input  1  vertical blanking from the timing generator, synchronous to pclk.
REQ-006 req  input  N_REQ  per-requester level request to access frame resources.
REQ-007 done  input  N_REQ  per-requester one-cycle pulse ending its access; ignored unless that requester holds gnt.
REQ-008 gnt  output  N_REQ  one-hot-or-zero grant, registered.
REQ-009 gnt_id  output  3  index of the granted requester; 0 when gnt is 0.
REQ-010 frame_start  output  1  one-cycle pulse on the first cycle vblnk is seen high.
REQ-011 abort  output  1  one-cycle pulse when a grant is revoked by window close or timeout.

Function
REQ-012 A window SHALL open on the cycle after a vblnk 0->1 edge and close on the cycle after a vblnk 1->0 edge; the vblnk edge SHALL be detected with one internal register of vblnk.
REQ-013 FSM states SHALL be IDLE, ARB, GRANT, and DRAIN.
REQ-014 IDLE: gnt=0; on window open, go to ARB and clear the per-window served mask.
REQ-015 ARB: if some requester has req=1 and is not served, select it round-robin starting at last_id+1 mod N_REQ, assert its gnt next cycle, and go to GRANT; if none is eligible, stay in ARB.
REQ-016 GRANT: hold gnt stable; on done[gnt_id], drop gnt next cycle, set served[gnt_id], update last_id, and go to ARB.
REQ-017 A requester SHALL be granted at most once per window; served SHALL clear only at window open.
REQ-018 Window close in ARB SHALL go to IDLE; window close in GRANT SHALL drop gnt next cycle, pulse abort, and go to DRAIN.
REQ-019 DRAIN SHALL last exactly one cycle with gnt=0, then go to IDLE.
REQ-020 req deasserted while granted SHALL NOT revoke gnt; only done, window close, or timeout revoke it.
REQ-021 Simultaneous done and window close SHALL count as done: served set, no abort.
REQ-022 gnt SHALL never be high while the registered vblnk is low, except for the single cycle the revocation takes effect.
REQ-023 Arbitration latency SHALL be one cycle from ARB with an eligible request to gnt high.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, gnt=0, gnt_id=0, frame_start=0, abort=0, served=0, last_id=N_REQ-1, vblnk register=0, and watchdog=0.
REQ-025 Reset deasserted mid-vblank SHALL NOT open a window until the next 0->1 edge.

Configuration
REQ-026 Macro VBLANK_ARB_TIMEOUT_EN: when defined, a watchdog counts pclk cycles in GRANT.
REQ-027 With the macro defined, when the watchdog reaches TIMEOUT_CYC-1 without done, gnt SHALL drop, abort SHALL pulse, served SHALL be set for that requester, and the FSM SHALL go to ARB.
REQ-028 With the macro undefined, no watchdog logic SHALL exist, and GRANT SHALL wait indefinitely within the window.

Structure
REQ-029 Shared package vga_pkg SHALL hold the FSM state enum typedef, the default N_REQ and TIMEOUT_CYC constants, and the 1280x1024 blanking-length constants used by benches.
REQ-030 Sub-module rr_arbiter (inputs: eligible mask and last_id; outputs: valid and id) SHALL implement pure combinational round-robin selection.

Verification
REQ-031 req=4'b1111 and each done 10 cycles after its gnt -> grant order 0,1,2,3 in the first window; the second window starts at 0 again after last_id=3.
REQ-032 req[2] held high with done pulsed -> exactly one gnt[2] per window across 3 windows.
REQ-033 vblnk falls while gnt[1] is high -> gnt=0 next cycle, abort=1 for 1 cycle, one DRAIN cycle, served[1]=1.
REQ-034 With VBLANK_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no done -> gnt drops after 16 cycles, abort pulses, and the next eligible requester is granted 1 cycle later.
REQ-035 rst_n pulsed low during GRANT -> all outputs 0 immediately; no grant until the next vblnk rising edge.
REQ-036 done[3] and the vblnk fall in the same cycle with gnt[3] high -> no abort, and served[3] is set.
